// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter controller.
// Branch-type encodings, flush FSM states and the branch-condition helper.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JUMP = 2'b11
  } br_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch condition only; validity and FSM gating are applied by the caller.
  function automatic logic br_cond(input br_type_t br_type, input logic zero);
    logic cond;
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_JUMP: cond = 1'b1;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/pc_flush_fsm.sv
// Flush sequencer: after a taken redirect, holds flush_o high for
// flush_cycles_i cycles. The counter runs regardless of pipeline stalls.
module pc_flush_fsm
  import pc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       taken_i,
  input  logic [2:0] flush_cycles_i,
  output logic       idle_o,
  output logic       flush_o
);

  flush_state_t state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (taken_i) begin
          state_d = ST_FLUSH;
          cnt_d   = flush_cycles_i - 3'd1;
        end
      end
      ST_FLUSH: begin
        // cnt holds the number of flush cycles remaining after this one.
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign idle_o  = (state_q == ST_IDLE);
  assign flush_o = (state_q == ST_FLUSH);

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: owns the PC, resolves branch/jump outcomes,
// drives the PC-source select and starts a fixed-length flush on redirects.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [1:0]  br_type_i,
  input  logic        zero_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pc_src_o,
  output logic [31:0] next_pc_o,
  output logic        flush_o,
  output logic        misalign_o
);

  localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        taken;
  logic        fsm_idle;
  logic        fsm_flush;

  pc_flush_fsm u_flush_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .taken_i       (taken),
    .flush_cycles_i(FLUSH_LEN),
    .idle_o        (fsm_idle),
    .flush_o       (fsm_flush)
  );

  // Instructions presented while flushing are squashed, so they never redirect.
  always_comb begin
    taken    = br_valid_i & fsm_idle & br_cond(br_type_t'(br_type_i), zero_i);
    pc_plus4 = pc_q + PC_STEP;
    next_pc  = taken ? {br_target_i[31:2], 2'b00} : pc_plus4;
  end

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (taken) begin
      pc_d       = next_pc;
      misalign_d = |br_target_i[1:0];
    end else if (!stall_i) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign pc_src_o   = taken;
  assign next_pc_o  = next_pc;
  assign flush_o    = fsm_flush;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed rows push hand-computed expectations,
// a negedge monitor pops and compares every cycle the DUT presents outputs.
module tb_pc_ctrl;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_BEQ  = 2'b01;
  localparam logic [1:0] T_BNE  = 2'b10;
  localparam logic [1:0] T_JUMP = 2'b11;

  typedef struct {
    int          row;
    logic [31:0] pc;
    logic        src;
    logic [31:0] nxt;
    logic        flush;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_valid_i;
  logic [1:0]  br_type_i;
  logic        zero_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pc_src_o;
  logic [31:0] next_pc_o;
  logic        flush_o;
  logic        misalign_o;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   row_id = 0;

  pc_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_i),
    .br_valid_i (br_valid_i),
    .br_type_i  (br_type_i),
    .zero_i     (zero_i),
    .br_target_i(br_target_i),
    .pc_o       (pc_o),
    .pc_plus4_o (pc_plus4_o),
    .pc_src_o   (pc_src_o),
    .next_pc_o  (next_pc_o),
    .flush_o    (flush_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL row%0d %s: got %h want %h", row, nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_o",       e.row, pc_o,              e.pc);
      chk("pc_plus4_o", e.row, pc_plus4_o,        e.pc + 32'd4);
      chk("pc_src_o",   e.row, {31'd0, pc_src_o}, {31'd0, e.src});
      chk("next_pc_o",  e.row, next_pc_o,         e.nxt);
      chk("flush_o",    e.row, {31'd0, flush_o},  {31'd0, e.flush});
      chk("misalign_o", e.row, {31'd0, misalign_o}, {31'd0, e.mis});
    end
  end

  // One cycle: drive inputs, push what the DUT must show this cycle.
  task automatic step(input logic r, input logic s, input logic bv,
                      input logic [1:0] t, input logic z, input logic [31:0] tg,
                      input logic [31:0] epc, input logic esrc,
                      input logic [31:0] enx, input logic efl, input logic emis);
    exp_t e;
    rst_n       = r;
    stall_i     = s;
    br_valid_i  = bv;
    br_type_i   = t;
    zero_i      = z;
    br_target_i = tg;
    e.row   = row_id;
    e.pc    = epc;
    e.src   = esrc;
    e.nxt   = enx;
    e.flush = efl;
    e.mis   = emis;
    exp_q.push_back(e);
    row_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; br_valid_i = 1'b0;
    br_type_i = T_NONE; zero_i = 1'b0; br_target_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    //     rst s  bv type   z  target        pc            src nxt           fl mis
    step(0, 0, 0, T_NONE, 0, 32'h0,        32'h0,        0, 32'h4,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h0,        0, 32'h4,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h4,        0, 32'h8,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h8,        0, 32'hC,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'hC,        0, 32'h10,       0, 0);
    step(1, 0, 1, T_BEQ,  1, 32'h40,       32'h10,       1, 32'h40,       0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h40,       0, 32'h44,       1, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h44,       0, 32'h48,       1, 0);
    step(1, 0, 1, T_JUMP, 0, 32'h10,       32'h48,       1, 32'h10,       0, 0);
    step(1, 1, 0, T_NONE, 0, 32'h0,        32'h10,       0, 32'h14,       1, 0);
    step(1, 1, 0, T_NONE, 0, 32'h0,        32'h10,       0, 32'h14,       1, 0);
    step(1, 0, 1, T_BNE,  1, 32'h300,      32'h10,       0, 32'h14,       0, 0);
    step(1, 1, 1, T_JUMP, 0, 32'h100,      32'h14,       1, 32'h100,      0, 0);
    step(1, 1, 0, T_NONE, 0, 32'h0,        32'h100,      0, 32'h104,      1, 0);
    step(1, 0, 1, T_BEQ,  1, 32'h200,      32'h100,      0, 32'h104,      1, 0);
    step(1, 0, 1, T_BNE,  0, 32'h80,       32'h104,      1, 32'h80,       0, 0);
    step(1, 0, 1, T_JUMP, 0, 32'h500,      32'h80,       0, 32'h84,       1, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h84,       0, 32'h88,       1, 0);
    step(1, 0, 1, T_BEQ,  0, 32'h600,      32'h88,       0, 32'h8C,       0, 0);
    step(1, 0, 1, T_NONE, 1, 32'h700,      32'h8C,       0, 32'h90,       0, 0);
    step(1, 0, 1, T_JUMP, 0, 32'h103,      32'h90,       1, 32'h100,      0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h100,      0, 32'h104,      1, 1);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h104,      0, 32'h108,      1, 0);
    step(1, 0, 0, T_JUMP, 0, 32'h900,      32'h108,      0, 32'h10C,      0, 0);
    step(1, 0, 1, T_JUMP, 0, 32'hFFFF_FFFC, 32'h10C,     1, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,       1, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h0,        0, 32'h4,        1, 0);
    step(1, 0, 1, T_JUMP, 0, 32'h22,       32'h4,        1, 32'h20,       0, 0);
    step(0, 0, 0, T_NONE, 0, 32'h0,        32'h0,        0, 32'h4,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h0,        0, 32'h4,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h4,        0, 32'h8,        0, 0);
    step(1, 0, 0, T_NONE, 0, 32'h0,        32'h8,        0, 32'hC,        0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
